rhs_stim_sequencer: RTL and testbench

Sequences a biphasic stimulation pulse train on the two RHS2116 chips behind the SPI engine (MOSI1/MOSI2 lanes). Takes the stim configuration already held in the AXI-lite register bank: channel pair, pulse width, intrapulse delay, pulse count and infinite mode. It times phases on a 50 us tick and issues stim-polarity and stim-on register writes as command frames to the SPI command engine over a valid/ready handshake. Sits between the register bank (ctrl bit3 = stim enable, status bit16 = stim done) and the SPI frame engine.

---
 rtl/rhs_pkg.sv | 50 +++++
 rtl/rhs_tick_gen.sv | 51 +++++
 rtl/rhs_stim_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rhs_stim_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhs_pkg.sv
// Shared constants, state encoding and the per-lane command word builder
// used by the RHS2116 stimulation sequencer.
package rhs_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_A_POL  = 4'd1;
    localparam state_t ST_A_ON   = 4'd2;
    localparam state_t ST_A_HOLD = 4'd3;
    localparam state_t ST_A_OFF  = 4'd4;
    localparam state_t ST_GAP1   = 4'd5;
    localparam state_t ST_B_POL  = 4'd6;
    localparam state_t ST_B_ON   = 4'd7;
    localparam state_t ST_B_HOLD = 4'd8;
    localparam state_t ST_B_OFF  = 4'd9;
    localparam state_t ST_GAP2   = 4'd10;
    localparam state_t ST_DONE   = 4'd11;
    localparam state_t ST_KILL   = 4'd12;

    localparam logic [7:0] REG_STIM_ON  = 8'd42;
    localparam logic [7:0] REG_STIM_POL = 8'd44;
    localparam logic [1:0] CMD_WRITE    = 2'b10;

    localparam logic [31:0] OFF_WORD = {CMD_WRITE, 1'b1, 1'b0, 4'b0000, REG_STIM_ON, 16'h0000};

    // Electrode bit [4] picks the chip; a lane only carries bits for its own chip.
    // POL words mark the currently positive electrode; invert swaps the roles for phase B.
    function automatic logic [31:0] lane_word(
        input logic [7:0] addr,
        input logic       u,
        input logic [4:0] pos,
        input logic [4:0] neg,
        input logic       mono,
        input logic       lane,
        input logic       invert
    );
        logic [15:0] data;
        data = 16'h0000;
        if (addr == REG_STIM_POL) begin
            if (pos[4] == lane) data[pos[3:0]] = ~invert;
            if (!mono && neg[4] == lane && invert) data[neg[3:0]] = 1'b1;
        end else begin
            if (pos[4] == lane) data[pos[3:0]] = 1'b1;
            if (!mono && neg[4] == lane) data[neg[3:0]] = 1'b1;
        end
        return {CMD_WRITE, u, 1'b0, 4'b0000, addr, data};
    endfunction

endpackage

// File: rtl/rhs_tick_gen.sv
// Phase timer: a TICK_CYCLES prescaler feeding a loadable duration counter.
// expire pulses on the final cycle of a load_val * TICK_CYCLES interval.
module rhs_tick_gen #(
    parameter int TICK_CYCLES = 2800,
    parameter int DUR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DUR_W-1:0] load_val,
    output logic             expire
);

    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               tick;

    assign tick   = (dur_q != '0) && (presc_q == PRESC_LAST);
    assign expire = tick && (dur_q == DUR_W'(1));

    // The duration counter parks at zero, so neither counter can wrap.
    always_comb begin
        presc_d = presc_q;
        dur_d   = dur_q;
        if (restart) begin
            presc_d = '0;
            dur_d   = load_val;
        end else if (dur_q != '0) begin
            if (tick) begin
                presc_d = '0;
                dur_d   = dur_q - 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            dur_q   <= '0;
        end else begin
            presc_q <= presc_d;
            dur_q   <= dur_d;
        end
    end

endmodule

// File: rtl/rhs_stim_sequencer.sv
// Biphasic stimulation pulse-train sequencer for two RHS2116 chips. Emits
// polarity / stim-on / stim-off register writes as SPI command frames.
module rhs_stim_sequencer
    import rhs_pkg::*;
#(
    parameter int TICK_CYCLES = 2800,
    parameter int PW_W        = 16,
    parameter int NP_W        = 10
) (
    input  logic            s00_axi_aclk,
    input  logic            s00_axi_aresetn,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      chan_pos,
    input  logic [4:0]      chan_neg,
    input  logic            monopolar,
    input  logic [PW_W-1:0] pulse_width,
    input  logic [PW_W-1:0] ipd,
    input  logic [NP_W-1:0] num_pulse,
    input  logic            infinite,
    output logic [31:0]     cmd_data1,
    output logic [31:0]     cmd_data2,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic            busy,
    output logic            done,
    output state_t          state_dbg
);

    // Handshake: a frame transfers on any cycle where cmd_valid && cmd_ready;
    // once raised, cmd_valid and cmd_data hold until that transfer.

    state_t          state_q, state_d;
    logic [4:0]      pos_q, pos_d, neg_q, neg_d;
    logic            mono_q, mono_d, inf_q, inf_d, done_q, done_d;
    logic [PW_W-1:0] pw_q, pw_d, ipd_q, ipd_d;
    logic [NP_W-1:0] np_q, np_d;
    logic [NP_W:0]   cnt_q, cnt_d, cnt_inc;
    logic            accept, ipd_zero, last_pulse;
    logic            tick_restart, tick_expire;
    logic [PW_W-1:0] tick_load;

    assign accept     = cmd_valid && cmd_ready;
    assign ipd_zero   = (ipd_q == '0);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign last_pulse = !inf_q && (cnt_inc == ({1'b0, np_q} + 1'b1));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        mono_d  = mono_q;
        inf_d   = inf_q;
        pw_d    = pw_q;
        ipd_d   = ipd_q;
        np_d    = np_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    pos_d   = chan_pos;
                    neg_d   = chan_neg;
                    mono_d  = monopolar;
                    inf_d   = infinite;
                    pw_d    = pulse_width;
                    ipd_d   = ipd;
                    np_d    = num_pulse;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = ST_A_POL;
                end
            end
            ST_A_POL:  if (accept) state_d = abort ? ST_IDLE : ST_A_ON;
            ST_A_ON:   if (accept) state_d = abort ? ST_KILL : ST_A_HOLD;
            ST_A_HOLD: begin
                if (abort)            state_d = ST_KILL;
                else if (tick_expire) state_d = ST_A_OFF;
            end
            ST_A_OFF: begin
                if (accept) state_d = abort ? ST_IDLE : (ipd_zero ? ST_B_POL : ST_GAP1);
            end
            ST_GAP1: begin
                if (abort)            state_d = ST_IDLE;
                else if (tick_expire) state_d = ST_B_POL;
            end
            ST_B_POL:  if (accept) state_d = abort ? ST_IDLE : ST_B_ON;
            ST_B_ON:   if (accept) state_d = abort ? ST_KILL : ST_B_HOLD;
            ST_B_HOLD: begin
                if (abort)            state_d = ST_KILL;
                else if (tick_expire) state_d = ST_B_OFF;
            end
            ST_B_OFF: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else if (last_pulse) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ipd_zero ? ST_A_POL : ST_GAP2;
                    end
                end
            end
            ST_GAP2: begin
                if (abort)            state_d = ST_IDLE;
                else if (tick_expire) state_d = ST_A_POL;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_KILL: if (accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The timer reloads on every entry into a HOLD or GAP state.
    assign tick_restart = (state_d != state_q) &&
                          (state_d == ST_A_HOLD || state_d == ST_B_HOLD ||
                           state_d == ST_GAP1   || state_d == ST_GAP2);

    always_comb begin
        tick_load = (pw_q == '0) ? PW_W'(1) : pw_q;
        if (state_d == ST_GAP1 || state_d == ST_GAP2) tick_load = ipd_q;
    end

    rhs_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .DUR_W       (PW_W)
    ) u_tick_gen (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .restart  (tick_restart),
        .load_val (tick_load),
        .expire   (tick_expire)
    );

    always_comb begin
        cmd_valid = 1'b0;
        cmd_data1 = 32'h0;
        cmd_data2 = 32'h0;
        case (state_q)
            ST_A_POL: begin
                cmd_valid = 1'b1;
                cmd_data1 = lane_word(REG_STIM_POL, 1'b0, pos_q, neg_q, mono_q, 1'b0, 1'b0);
                cmd_data2 = lane_word(REG_STIM_POL, 1'b0, pos_q, neg_q, mono_q, 1'b1, 1'b0);
            end
            ST_B_POL: begin
                cmd_valid = 1'b1;
                cmd_data1 = lane_word(REG_STIM_POL, 1'b0, pos_q, neg_q, mono_q, 1'b0, 1'b1);
                cmd_data2 = lane_word(REG_STIM_POL, 1'b0, pos_q, neg_q, mono_q, 1'b1, 1'b1);
            end
            ST_A_ON, ST_B_ON: begin
                cmd_valid = 1'b1;
                cmd_data1 = lane_word(REG_STIM_ON, 1'b1, pos_q, neg_q, mono_q, 1'b0, 1'b0);
                cmd_data2 = lane_word(REG_STIM_ON, 1'b1, pos_q, neg_q, mono_q, 1'b1, 1'b0);
            end
            ST_A_OFF, ST_B_OFF, ST_KILL: begin
                cmd_valid = 1'b1;
                cmd_data1 = OFF_WORD;
                cmd_data2 = OFF_WORD;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = done_q;
    assign state_dbg = state_q;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            neg_q   <= '0;
            mono_q  <= 1'b0;
            inf_q   <= 1'b0;
            pw_q    <= '0;
            ipd_q   <= '0;
            np_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            mono_q  <= mono_d;
            inf_q   <= inf_d;
            pw_q    <= pw_d;
            ipd_q   <= ipd_d;
            np_q    <= np_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Self-checking bench for rhs_stim_sequencer: directed and randomized pulse
// trains compared frame-by-frame and cycle-by-cycle against a reference model.
module tb_rhs_stim_sequencer;

    localparam int T = 10;

    typedef struct {
        logic [4:0]  pos;
        logic [4:0]  neg;
        logic        mono;
        logic [15:0] pw;
        logic [15:0] ipd;
        logic [9:0]  np;
        logic        inf;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  pos = '0;
    logic [4:0]  neg = '0;
    logic        mono = 1'b0;
    logic [15:0] pw = '0;
    logic [15:0] ipd = '0;
    logic [9:0]  np = '0;
    logic        inf = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [31:0] d1, d2;
    logic        cmd_valid, busy, done;
    logic [3:0]  state_dbg;

    // clock / reset
    always #5 clk = ~clk;

    rhs_stim_sequencer #(
        .TICK_CYCLES (T),
        .PW_W        (16),
        .NP_W        (10)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rstn),
        .start           (start),
        .abort           (abort),
        .chan_pos        (pos),
        .chan_neg        (neg),
        .monopolar       (mono),
        .pulse_width     (pw),
        .ipd             (ipd),
        .num_pulse       (np),
        .infinite        (inf),
        .cmd_data1       (d1),
        .cmd_data2       (d2),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .busy            (busy),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    // scoreboard
    logic [63:0] exp_q[$];
    int          exp_dly_q[$];
    logic [63:0] got_q[$];
    int          got_rise_q[$];
    int          got_acc_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stall_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records every accepted frame with the cycle its valid rose and the cycle it was taken.
    initial begin : monitor
        logic        pend;
        logic [63:0] pend_data;
        int          rise;
        pend = 1'b0;
        pend_data = '0;
        rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                pend = 1'b0;
            end else if (cmd_valid) begin
                if (pend) check("data_stable", {d1, d2}, pend_data);
                else begin
                    pend = 1'b1;
                    pend_data = {d1, d2};
                    rise = cyc;
                end
                if (cmd_ready) begin
                    got_q.push_back({d1, d2});
                    got_rise_q.push_back(rise);
                    got_acc_q.push_back(cyc);
                    pend = 1'b0;
                end
            end else if (pend) begin
                check("valid_held", 64'(cmd_valid), 64'd1);
                pend = 1'b0;
            end
        end
    end

    // SPI-engine stand-in: holds ready low for stall_cyc cycles of each frame.
    initial begin : ready_drv
        int   wait_cnt;
        logic was_acc;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            was_acc = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (was_acc) wait_cnt = 0;
            if (cmd_valid) begin
                cmd_ready = (wait_cnt >= stall_cyc);
                wait_cnt++;
            end else begin
                cmd_ready = (stall_cyc == 0);
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [63:0] frame(input bit u, input logic [7:0] rg,
                                          input logic [15:0] m1, input logic [15:0] m2);
        return {2'b10, u, 1'b0, 4'h0, rg, m1, 2'b10, u, 1'b0, 4'h0, rg, m2};
    endfunction

    // Set of electrodes on one chip: pos and/or neg, neg dropped when monopolar.
    function automatic logic [15:0] lane_mask(input cfg_t c, input bit lane,
                                              input bit with_pos, input bit with_neg);
        logic [15:0] m;
        m = 16'h0;
        if (with_pos && c.pos[4] == lane) m = m | (16'h1 << c.pos[3:0]);
        if (with_neg && !c.mono && c.neg[4] == lane) m = m | (16'h1 << c.neg[3:0]);
        return m;
    endfunction

    // Expected frames plus, per frame, cycles from previous acceptance to valid rising.
    task automatic model(input cfg_t c, input int pulses);
        int          hold, gap;
        logic [63:0] off;
        hold = ((c.pw == 0) ? 1 : int'(c.pw)) * T + 1;
        gap  = int'(c.ipd) * T + 1;
        off  = frame(1'b1, 8'd42, 16'h0, 16'h0);
        exp_q.delete();
        exp_dly_q.delete();
        for (int p = 0; p < pulses; p++) begin
            exp_q.push_back(frame(1'b0, 8'd44, lane_mask(c, 0, 1, 0), lane_mask(c, 1, 1, 0)));
            exp_dly_q.push_back(p == 0 ? -1 : gap);
            exp_q.push_back(frame(1'b1, 8'd42, lane_mask(c, 0, 1, 1), lane_mask(c, 1, 1, 1)));
            exp_dly_q.push_back(1);
            exp_q.push_back(off);
            exp_dly_q.push_back(hold);
            exp_q.push_back(frame(1'b0, 8'd44, lane_mask(c, 0, 0, 1), lane_mask(c, 1, 0, 1)));
            exp_dly_q.push_back(gap);
            exp_q.push_back(frame(1'b1, 8'd42, lane_mask(c, 0, 1, 1), lane_mask(c, 1, 1, 1)));
            exp_dly_q.push_back(1);
            exp_q.push_back(off);
            exp_dly_q.push_back(hold);
        end
    endtask

    task automatic truncate_and_kill(input int keep);
        while (exp_q.size() > keep) begin
            void'(exp_q.pop_back());
            void'(exp_dly_q.pop_back());
        end
        exp_q.push_back(frame(1'b1, 8'd42, 16'h0, 16'h0));
        exp_dly_q.push_back(-1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
            if (i > 0 && exp_dly_q[i] >= 0)
                check($sformatf("%s_dly%0d", tag, i),
                      64'(got_rise_q[i] - got_acc_q[i-1]), 64'(exp_dly_q[i]));
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 64'hx;
    endfunction

    function automatic int span(input int i);
        return (i > 0 && i < got_q.size()) ? got_rise_q[i] - got_acc_q[i-1] - 1 : -1;
    endfunction

    // driver tasks
    function automatic cfg_t mk_cfg(input logic [4:0] p, input logic [4:0] n, input logic m,
                                    input int w, input int g, input int k, input logic f);
        cfg_t c;
        c.pos = p; c.neg = n; c.mono = m;
        c.pw = 16'(w); c.ipd = 16'(g); c.np = 10'(k); c.inf = f;
        return c;
    endfunction

    function automatic logic [4:0] rand_chan();
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic apply_cfg(input cfg_t c);
        pos = c.pos; neg = c.neg; mono = c.mono;
        pw = c.pw; ipd = c.ipd; np = c.np; inf = c.inf;
    endtask

    task automatic do_start(input cfg_t c);
        @(negedge clk);
        apply_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_rise_q.delete();
        got_acc_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_frames(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (got_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frames_seen"}, 64'(got_q.size() >= cnt), 64'd1);
    endtask

    initial begin : stimulus
        cfg_t c, c2;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_data", {d1, d2}, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rstn = 1'b1;

        // Bipolar on chip 1, exact frames and timings
        stall_cyc = 0;
        clear_obs();
        c = mk_cfg(5'd17, 5'd18, 1'b0, 1, 16, 1, 1'b0);
        do_start(c);
        check("t1_busy", 64'(busy), 64'd1);
        wait_idle("t1", 3000);
        model(c, 2);
        compare("t1");
        check("t1_done", 64'(done), 64'd1);
        check("t1_pol_a", got_at(0), 64'h802C0000_802C0002);
        check("t1_on", got_at(1), 64'hA02A0000_A02A0006);
        check("t1_off", got_at(2), 64'hA02A0000_A02A0000);
        check("t1_pol_b", got_at(3), 64'h802C0000_802C0004);
        check("t1_hold", 64'(span(2)), 64'd10);
        check("t1_gap", 64'(span(3)), 64'd160);

        // Monopolar cross-chip, no gap
        clear_obs();
        c = mk_cfg(5'd3, 5'd20, 1'b1, 2, 0, 0, 1'b0);
        do_start(c);
        check("t2_done_clr", 64'(done), 64'd0);
        wait_idle("t2", 2000);
        model(c, 1);
        compare("t2");
        check("t2_on", got_at(1), 64'hA02A0008_A02A0000);
        check("t2_off", got_at(2), 64'hA02A0000_A02A0000);
        check("t2_done", 64'(done), 64'd1);

        // Back-pressure: ready low 7 cycles per frame
        stall_cyc = 7;
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'b0, 1, 1, 0, 1'b0);
        do_start(c);
        wait_idle("t3", 3000);
        model(c, 1);
        compare("t3");
        check("t3_hold", 64'(span(2)), 64'd10);

        // Abort mid A_HOLD: one OFF then idle; start ignored while abort is high
        stall_cyc = 0;
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'($urandom_range(0, 1)), 3, 1, 3, 1'b0);
        do_start(c);
        wait_frames("t4a", 2, 200);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        wait_idle("t4a", 200);
        do_start(c);
        check("t4a_start_blocked", 64'(busy), 64'd0);
        abort = 1'b0;
        model(c, 1);
        truncate_and_kill(2);
        compare("t4a");
        check("t4a_done", 64'(done), 64'd0);

        // Abort while A_POL is pending: POL completes, no OFF
        stall_cyc = 7;
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'b0, 1, 1, 0, 1'b0);
        do_start(c);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        wait_idle("t4b", 200);
        @(negedge clk);
        abort = 1'b0;
        model(c, 1);
        while (exp_q.size() > 1) begin
            void'(exp_q.pop_back());
            void'(exp_dly_q.pop_back());
        end
        compare("t4b");
        check("t4b_done", 64'(done), 64'd0);

        // Infinite: run past the programmed count, then abort during the 6th pulse
        stall_cyc = 0;
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'b0, 1, 2, 0, 1'b1);
        do_start(c);
        wait_frames("t5a", 32, 5000);
        abort = 1'b1;
        wait_idle("t5a", 500);
        @(negedge clk);
        abort = 1'b0;
        model(c, 6);
        truncate_and_kill(32);
        compare("t5a");
        check("t5a_done", 64'(done), 64'd0);

        // pw=0 acts as 1, ipd=0 skips the gaps
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'b0, 0, 0, 2, 1'b0);
        do_start(c);
        wait_idle("t5b", 2000);
        model(c, 3);
        compare("t5b");
        check("t5b_hold", 64'(span(2)), 64'(T));
        check("t5b_nogap", 64'(span(3)), 64'd0);

        // Second start while busy is ignored, including its config
        clear_obs();
        c  = mk_cfg(rand_chan(), rand_chan(), 1'b0, 2, 1, 1, 1'b0);
        c2 = mk_cfg(~c.pos, ~c.neg, 1'b1, 5, 3, 4, 1'b0);
        do_start(c);
        wait_frames("t6a", 2, 200);
        do_start(c2);
        wait_idle("t6a", 3000);
        model(c, 2);
        compare("t6a");
        check("t6a_done", 64'(done), 64'd1);

        // Reset in the middle of A_HOLD
        clear_obs();
        c = mk_cfg(rand_chan(), rand_chan(), 1'b0, 3, 1, 1, 1'b0);
        do_start(c);
        wait_frames("t6b", 2, 200);
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("t6b_valid", 64'(cmd_valid), 64'd0);
        check("t6b_data", {d1, d2}, 64'h0);
        check("t6b_busy", 64'(busy), 64'd0);
        check("t6b_done", 64'(done), 64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("t6b_quiet", 64'(got_q.size()), 64'd2);

        // Randomized configurations and back-pressure
        for (int it = 0; it < 4; it++) begin
            stall_cyc = $urandom_range(0, 3);
            clear_obs();
            c = mk_cfg(rand_chan(), rand_chan(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
            do_start(c);
            wait_idle($sformatf("rnd%0d", it), 3000);
            model(c, int'(c.np) + 1);
            compare($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_done", it), 64'(done), 64'd1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
